// File: rtl/output_sched_pkg.sv
// Shared constants, FSM encoding and address helper for the output write scheduler.
package output_sched_pkg;

    localparam logic [7:0] AXI_LEN        = 8'd7;
    localparam logic [2:0] AXI_SIZE       = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE      = 4'b0011;

    localparam int ROW_SHIFT   = 6;
    localparam int LAYER_SHIFT = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } state_t;

    // One layer occupies a 4 KB page; one row is a 64-byte burst inside it.
    function automatic logic [31:0] row_addr(input logic [31:0] base,
                                             input logic [10:0] layer,
                                             input logic [9:0]  row);
        row_addr = base + ({21'd0, layer} << LAYER_SHIFT) + ({22'd0, row} << ROW_SHIFT);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request after the last grant.
module rr_arbiter
    import output_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    logic [PW-1:0] idx_s;

    // Scan requesters starting one past the last grant, wrapping around.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx_s = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = PW'((int'(last_grant) + k) % NUM_REQ);
            if (!valid && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_write_scheduler.sv
// Drains per-channel output FIFOs into DDR3 via one AXI4 write master,
// one 8-beat burst per row, round-robin among FIFOs holding a full row.
module output_write_scheduler
    import output_sched_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 3,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int C_S_AXI_BURST_LEN  = 8,
    parameter int NUM_REQ            = 3
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         axi_address,
    input  logic [9:0]                            no_of_output_layers,
    input  logic [9:0]                            output_row_size,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  bresp_err,
    input  logic [NUM_REQ*C_S_AXI_DATA_WIDTH-1:0] fifo_data,
    input  logic [NUM_REQ*10-1:0]                 fifo_dcount,
    output logic [NUM_REQ-1:0]                    fifo_rd_en,
    output logic [C_S_AXI_ID_WIDTH-1:0]           M_axi_awid,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]         M_axi_awaddr,
    output logic [7:0]                            M_axi_awlen,
    output logic [2:0]                            M_axi_awsize,
    output logic [1:0]                            M_axi_awburst,
    output logic                                  M_axi_awlock,
    output logic [3:0]                            M_axi_awcache,
    output logic [2:0]                            M_axi_awprot,
    output logic [3:0]                            M_axi_awqos,
    output logic                                  M_axi_awvalid,
    input  logic                                  M_axi_awready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         M_axi_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]       M_axi_wstrb,
    output logic                                  M_axi_wlast,
    output logic                                  M_axi_wvalid,
    input  logic                                  M_axi_wready,
    input  logic [1:0]                            M_axi_bresp,
    input  logic                                  M_axi_bvalid,
    output logic                                  M_axi_bready
);

    localparam int         PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] LAST_BEAT = 3'(C_S_AXI_BURST_LEN - 1);

    state_t                        state_q, state_d;
    logic [PW-1:0]                 grant_q, grant_d;
    logic [PW-1:0]                 last_q, last_d;
    logic [2:0]                    beat_q, beat_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;
    logic [31:0]                   base_q, base_d;
    logic [9:0]                    layers_q, layers_d;
    logic [9:0]                    rows_q, rows_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [10:0]                   layer_id_q [NUM_REQ];
    logic [10:0]                   layer_id_d [NUM_REQ];
    logic [9:0]                    row_id_q   [NUM_REQ];
    logic [9:0]                    row_id_d   [NUM_REQ];

    logic [NUM_REQ-1:0] active_s;
    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] arb_grant_s;
    logic               arb_valid_s;
    logic [PW-1:0]      arb_idx_s;

    // Per-requester activity and eligibility; layer_id is one bit wider so +NUM_REQ never wraps.
    always_comb begin
        active_s   = '0;
        eligible_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            active_s[i]   = (layer_id_q[i] < {1'b0, layers_q}) && (rows_q != 10'd0);
            eligible_s[i] = busy_q && active_s[i] && (fifo_dcount[10*i +: 10] >= 10'd8);
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_arb (
        .req        (eligible_s),
        .last_grant (last_q),
        .grant      (arb_grant_s),
        .valid      (arb_valid_s)
    );

    // One-hot grant to index.
    always_comb begin
        arb_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant_s[i]) begin
                arb_idx_s = PW'(i);
            end else begin
                arb_idx_s = arb_idx_s;
            end
        end
    end

    // Next-state and counter logic for the burst FSM.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        beat_d   = beat_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        base_d   = base_q;
        layers_d = layers_q;
        rows_d   = rows_q;
        awaddr_d = awaddr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            layer_id_d[i] = layer_id_q[i];
            row_id_d[i]   = row_id_q[i];
        end

        if (start && !busy_q) begin
            base_d   = axi_address;
            layers_d = no_of_output_layers;
            rows_d   = output_row_size;
            last_d   = PW'(NUM_REQ - 1);
            err_d    = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                layer_id_d[i] = 11'(i);
                row_id_d[i]   = 10'd0;
            end
            // An empty job finishes immediately without ever raising busy.
            if ((no_of_output_layers == 10'd0) || (output_row_size == 10'd0)) begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end else begin
                done_d = 1'b0;
                busy_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (busy_q && (active_s == '0)) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else if (busy_q && arb_valid_s) begin
                        grant_d  = arb_idx_s;
                        last_d   = arb_idx_s;
                        awaddr_d = row_addr(base_q, layer_id_q[arb_idx_s], row_id_q[arb_idx_s]);
                        state_d  = AW;
                    end else begin
                        state_d = IDLE;
                    end
                end
                AW: begin
                    if (M_axi_awready) begin
                        state_d = W;
                        beat_d  = 3'd0;
                    end else begin
                        state_d = AW;
                    end
                end
                W: begin
                    if (M_axi_wready) begin
                        if (beat_q == LAST_BEAT) begin
                            state_d = B;
                        end else begin
                            beat_d = beat_q + 3'd1;
                        end
                    end else begin
                        beat_d = beat_q;
                    end
                end
                B: begin
                    if (M_axi_bvalid) begin
                        if (row_id_q[grant_q] == (rows_q - 10'd1)) begin
                            row_id_d[grant_q]   = 10'd0;
                            layer_id_d[grant_q] = layer_id_q[grant_q] + 11'(NUM_REQ);
                        end else begin
                            row_id_d[grant_q] = row_id_q[grant_q] + 10'd1;
                        end
                        if (M_axi_bresp != 2'b00) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                        state_d = IDLE;
                    end else begin
                        state_d = B;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= PW'(NUM_REQ - 1);
            beat_q   <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            base_q   <= 32'd0;
            layers_q <= 10'd0;
            rows_q   <= 10'd0;
            awaddr_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                layer_id_q[i] <= 11'd0;
                row_id_q[i]   <= 10'd0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            base_q   <= base_d;
            layers_q <= layers_d;
            rows_q   <= rows_d;
            awaddr_q <= awaddr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                layer_id_q[i] <= layer_id_d[i];
                row_id_q[i]   <= row_id_d[i];
            end
        end
    end

    // Write data is taken straight from the granted FIFO head; pops follow W handshakes.
    always_comb begin
        M_axi_wdata = '0;
        fifo_rd_en  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == PW'(i)) begin
                M_axi_wdata   = fifo_data[C_S_AXI_DATA_WIDTH*i +: C_S_AXI_DATA_WIDTH];
                fifo_rd_en[i] = (state_q == W) && M_axi_wready;
            end else begin
                fifo_rd_en[i] = 1'b0;
            end
        end
    end

    assign M_axi_awid    = '0;
    assign M_axi_awaddr  = awaddr_q;
    assign M_axi_awlen   = AXI_LEN;
    assign M_axi_awsize  = AXI_SIZE;
    assign M_axi_awburst = AXI_BURST_INCR;
    assign M_axi_awlock  = 1'b0;
    assign M_axi_awcache = AXI_CACHE;
    assign M_axi_awprot  = 3'd0;
    assign M_axi_awqos   = 4'd0;
    assign M_axi_awvalid = (state_q == AW);
    assign M_axi_wstrb   = {(C_S_AXI_DATA_WIDTH/8){1'b1}};
    assign M_axi_wvalid  = (state_q == W);
    assign M_axi_wlast   = (state_q == W) && (beat_q == LAST_BEAT);
    assign M_axi_bready  = (state_q == B);
    assign busy          = busy_q;
    assign done          = done_q;
    assign bresp_err     = err_q;

endmodule

// File: tb/tb_output_write_scheduler.sv
// Bench for output_write_scheduler: FIFO/AXI slave models plus a round-robin job-list reference.
module tb_output_write_scheduler;

    localparam int NR = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n, start;
    logic [31:0]    axi_address;
    logic [9:0]     no_of_output_layers, output_row_size;
    logic           busy, done, bresp_err;
    logic [NR*64-1:0] fifo_data;
    logic [NR*10-1:0] fifo_dcount;
    logic [NR-1:0]  fifo_rd_en;
    logic [2:0]     awid;
    logic [31:0]    awaddr;
    logic [7:0]     awlen;
    logic [2:0]     awsize, awprot;
    logic [1:0]     awburst, bresp;
    logic           awlock, awvalid, awready;
    logic [3:0]     awcache, awqos;
    logic [63:0]    wdata;
    logic [7:0]     wstrb;
    logic           wlast, wvalid, wready, bvalid, bready;

    output_write_scheduler #(.NUM_REQ(NR)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .axi_address(axi_address),
        .no_of_output_layers(no_of_output_layers), .output_row_size(output_row_size),
        .busy(busy), .done(done), .bresp_err(bresp_err),
        .fifo_data(fifo_data), .fifo_dcount(fifo_dcount), .fifo_rd_en(fifo_rd_en),
        .M_axi_awid(awid), .M_axi_awaddr(awaddr), .M_axi_awlen(awlen), .M_axi_awsize(awsize),
        .M_axi_awburst(awburst), .M_axi_awlock(awlock), .M_axi_awcache(awcache),
        .M_axi_awprot(awprot), .M_axi_awqos(awqos), .M_axi_awvalid(awvalid),
        .M_axi_awready(awready), .M_axi_wdata(wdata), .M_axi_wstrb(wstrb),
        .M_axi_wlast(wlast), .M_axi_wvalid(wvalid), .M_axi_wready(wready),
        .M_axi_bresp(bresp), .M_axi_bvalid(bvalid), .M_axi_bready(bready)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] fq [NR][$];
    int          exp_req[$];
    logic [31:0] exp_addr[$];
    int          aw_idx, b_idx, beat, cur_req, mode, err_burst, cyc;
    logic        exp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_fifos();
        for (int i = 0; i < NR; i++) begin
            fifo_dcount[10*i +: 10] = 10'(fq[i].size());
            fifo_data[64*i +: 64]   = (fq[i].size() > 0) ? fq[i][0] : 64'd0;
        end
    endtask

    task automatic set_readies();
        case (mode)
            0: begin awready = 1'b1; wready = 1'b1; bvalid = 1'b1; end
            1: begin awready = 1'b1; wready = ~wready; bvalid = 1'b1; end
            default: begin
                awready = 1'($urandom_range(0, 1));
                wready  = 1'($urandom_range(0, 1));
                bvalid  = 1'($urandom_range(0, 1));
            end
        endcase
        bresp = (b_idx == err_burst) ? 2'b10 : 2'b00;
    endtask

    // One clock: observe at negedge, then update FIFO model and stimulus just after posedge.
    task automatic cycle();
        int   pop_req;
        logic b_hs;
        pop_req = -1;
        b_hs    = 1'b0;
        @(negedge clk);
        chk("aw_w_exclusive", 64'(awvalid & wvalid), 64'd0);
        if (awvalid && awready) begin
            chk("aw_const", 64'({awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, wstrb}),
                64'({3'd0, 8'd7, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 8'hFF}));
            if (aw_idx < exp_addr.size()) begin
                chk("aw_addr", 64'(awaddr), 64'(exp_addr[aw_idx]));
                cur_req = exp_req[aw_idx];
            end else begin
                chk("aw_count", 64'(aw_idx + 1), 64'(exp_addr.size()));
            end
            aw_idx++;
            beat = 0;
        end
        if (wvalid) begin
            chk("wlast", 64'(wlast), 64'(beat == 7));
            if (wready) begin
                if (fq[cur_req].size() > 0) chk("wdata", wdata, fq[cur_req][0]);
                else chk("fifo_underflow", 64'(fq[cur_req].size()), 64'd1);
                chk("rd_en", 64'(fifo_rd_en), 64'(1 << cur_req));
                pop_req = cur_req;
                beat++;
            end
        end else begin
            chk("rd_en_idle", 64'(fifo_rd_en), 64'd0);
        end
        if (bready && bvalid) begin
            b_hs = 1'b1;
            if (bresp != 2'b00) exp_err = 1'b1;
            b_idx++;
        end
        @(posedge clk);
        #1;
        if (pop_req >= 0 && fq[pop_req].size() > 0) void'(fq[pop_req].pop_front());
        if (b_hs) chk("bresp_err", 64'(bresp_err), 64'(exp_err));
        set_readies();
        drive_fifos();
    endtask

    // Reference job list: requester i owns layers i, i+NR, ...; each layer is rows 0..R-1;
    // with every FIFO stocked, jobs are taken round-robin among requesters with work left.
    task automatic build(input logic [31:0] base, input int L, input int R);
        int nl[NR];
        int nr[NR];
        int last, pick;
        bit found;
        exp_req.delete();
        exp_addr.delete();
        for (int i = 0; i < NR; i++) begin nl[i] = i; nr[i] = 0; fq[i].delete(); end
        last = NR - 1;
        while (L > 0 && R > 0) begin
            found = 1'b0;
            pick  = 0;
            for (int k = 1; k <= NR; k++) begin
                if (!found && nl[(last + k) % NR] < L) begin found = 1'b1; pick = (last + k) % NR; end
            end
            if (!found) break;
            exp_req.push_back(pick);
            exp_addr.push_back(base + 32'(nl[pick]) * 32'd4096 + 32'(nr[pick]) * 32'd64);
            for (int j = 0; j < 8; j++) fq[pick].push_back({$urandom, $urandom});
            nr[pick]++;
            if (nr[pick] == R) begin nr[pick] = 0; nl[pick] += NR; end
            last = pick;
        end
    endtask

    task automatic do_start(input logic [31:0] base, input int L, input int R);
        aw_idx = 0; b_idx = 0; beat = 0; cur_req = 0; exp_err = 1'b0;
        axi_address         = base;
        no_of_output_layers = 10'(L);
        output_row_size     = 10'(R);
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic begin_run(input logic [31:0] base, input int L, input int R);
        build(base, L, R);
        drive_fifos();
        do_start(base, L, R);
    endtask

    task automatic run_to_done(input int max_cyc);
        cyc = 0;
        while (!done && cyc < max_cyc) begin cycle(); cyc++; end
        chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic finish_run(input string tag);
        int left;
        left = 0;
        for (int i = 0; i < NR; i++) left += fq[i].size();
        chk({tag, "_aw_total"}, 64'(aw_idx), 64'(exp_addr.size()));
        chk({tag, "_b_total"}, 64'(b_idx), 64'(exp_addr.size()));
        chk({tag, "_words_left"}, 64'(left), 64'd0);
        chk({tag, "_busy_done"}, 64'({busy, done}), 64'({1'b0, 1'b1}));
        chk({tag, "_err"}, 64'(bresp_err), 64'(exp_err));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, 64'({awvalid, wvalid, wlast, bready, fifo_rd_en, busy, done, bresp_err}), 64'd0);
        chk({tag, "_awaddr"}, 64'(awaddr), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; axi_address = 32'd0;
        no_of_output_layers = 10'd0; output_row_size = 10'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        mode = 0; err_burst = -1; aw_idx = 0; b_idx = 0; beat = 0; cur_req = 0; exp_err = 1'b0;
        for (int i = 0; i < NR; i++) fq[i].delete();
        drive_fifos();
        repeat (3) cycle();
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        cycle();

        // Full-speed 3 layers x 2 rows: six back-to-back 11-cycle bursts.
        mode = 0;
        set_readies();
        begin_run(32'h1000_0000, 3, 2);
        run_to_done(2000);
        chk("t1_cycles_to_done", 64'(cyc), 64'd67);
        finish_run("t1");

        // Empty jobs complete right after start.
        begin_run(32'h1000_0000, 0, 5);
        chk("zero_layers_done", 64'({busy, done}), 64'({1'b0, 1'b1}));
        begin_run(32'h1000_0000, 4, 0);
        chk("zero_rows_done", 64'({busy, done}), 64'({1'b0, 1'b1}));

        // Toggling wready, error response on the second burst.
        mode = 1; err_burst = 1;
        set_readies();
        begin_run(32'h2000_0000, 3, 2);
        run_to_done(3000);
        finish_run("t_err");
        chk("err_sticky", 64'(bresp_err), 64'd1);
        err_burst = -1;

        // 4 layers, 1 row: requester 0 serves layers 0 and 3.
        mode = 0;
        set_readies();
        begin_run(32'h3000_0000, 4, 1);
        chk("err_cleared_by_start", 64'(bresp_err), 64'd0);
        run_to_done(2000);
        finish_run("t_l4");
        chk("t_l4_bursts", 64'(b_idx), 64'd4);

        // Only FIFO 1 has data, one word short of a row.
        build(32'h4000_0000, 3, 1);
        exp_req.delete(); exp_addr.delete();
        for (int i = 0; i < NR; i++) fq[i].delete();
        for (int j = 0; j < 7; j++) fq[1].push_back({$urandom, $urandom});
        exp_req.push_back(1);
        exp_addr.push_back(32'h4000_1000);
        drive_fifos();
        do_start(32'h4000_0000, 3, 1);
        for (int n = 0; n < 10; n++) begin
            cycle();
            chk("t2_no_awvalid", 64'(awvalid), 64'd0);
        end
        fq[1].push_back({$urandom, $urandom});
        drive_fifos();
        cycle();
        chk("t2_awvalid_rise", 64'(awvalid), 64'd1);
        chk("t2_awaddr", 64'(awaddr), 64'h4000_1000);
        repeat (12) cycle();
        chk("t2_bursts", 64'(b_idx), 64'd1);
        chk("t2_fifo1_empty", 64'(fq[1].size()), 64'd0);
        chk("t2_still_busy", 64'({busy, done}), 64'({1'b1, 1'b0}));
        reset_n = 1'b0;
        cycle();
        chk_reset_outputs("t2_reset");
        reset_n = 1'b1;

        // Reset in the middle of W beat 3, then a clean restart.
        begin_run(32'h1000_0000, 3, 2);
        cyc = 0;
        while (!(wvalid && beat == 3) && cyc < 100) begin cycle(); cyc++; end
        chk("t6_reached_beat3", 64'(wvalid && beat == 3), 64'd1);
        reset_n = 1'b0;
        cycle();
        chk_reset_outputs("t6_reset");
        reset_n = 1'b1;
        begin_run(32'h1000_0000, 3, 2);
        run_to_done(2000);
        finish_run("t6");

        // Randomised configurations and handshakes, with an ignored start pulse mid-run.
        for (int r = 0; r < 4; r++) begin
            mode      = 2;
            err_burst = $urandom_range(0, 6);
            set_readies();
            begin_run({$urandom_range(0, 1048575), 12'h000} & 32'hFFFF_F000,
                      $urandom_range(1, 7), $urandom_range(1, 3));
            repeat (4) cycle();
            axi_address         = 32'hDEAD_0000;
            no_of_output_layers = 10'd1;
            start = 1'b1;
            cycle();
            start = 1'b0;
            run_to_done(6000);
            finish_run("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
